// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// Receive-side byte handshake between the UART receiver and its consumer.
// The receiver drives the byte and its status flags; the consumer drives rx_ready.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver: 8 data bits LSB first, even parity, one stop bit, oversampled
// by an external baud_tick enable. Delivers each byte with parity/frame flags,
// holds it until the consumer handshakes, and flags an overrun when a new byte
// arrives while the previous one is still pending.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     baud_tick,
  input  logic     uart_rxd,
  output logic     uart_rts,
  uart_rx_if.master rxBus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_tickCnt;
  logic [2:0]      r_bitCnt;
  logic [7:0]      r_shift;
  logic            r_parityPend;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_parityErr;
  logic            r_frameErr;
  logic            r_overrun;

  logic            w_rxdS;
  logic            w_tickLast;
  logic            w_accept;

  assign w_rxdS     = r_sync2;
  assign w_tickLast = (r_tickCnt == TICK_LAST);
  assign w_accept   = !r_valid || rxBus.rx_ready;

  assign rxBus.rx_data     = r_data;
  assign rxBus.rx_valid    = r_valid;
  assign rxBus.parity_err  = r_parityErr;
  assign rxBus.frame_err   = r_frameErr;
  assign rxBus.overrun_err = r_overrun;
  assign uart_rts          = r_valid;

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM plus output holding registers; a delivery on the same edge as a
  // handshake overrides the clear because it is assigned later in the block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_tickCnt    <= '0;
      r_bitCnt     <= '0;
      r_shift      <= '0;
      r_parityPend <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parityErr  <= 1'b0;
      r_frameErr   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (r_valid && rxBus.rx_ready) begin
        r_valid     <= 1'b0;
        r_parityErr <= 1'b0;
        r_frameErr  <= 1'b0;
        r_overrun   <= 1'b0;
      end

      if (baud_tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rxdS) begin
              r_state   <= START;
              r_tickCnt <= '0;
            end
          end

          START: begin
            if (r_tickCnt == TICK_MID) begin
              r_tickCnt <= '0;
              r_bitCnt  <= '0;
              r_state   <= w_rxdS ? IDLE : DATA;
            end else begin
              r_tickCnt <= r_tickCnt + CW'(1);
            end
          end

          DATA: begin
            if (w_tickLast) begin
              r_tickCnt <= '0;
              r_shift   <= {w_rxdS, r_shift[7:1]};
              if (r_bitCnt == 3'd7) begin
                r_bitCnt <= '0;
                r_state  <= PARITY;
              end else begin
                r_bitCnt <= r_bitCnt + 3'd1;
              end
            end else begin
              r_tickCnt <= r_tickCnt + CW'(1);
            end
          end

          PARITY: begin
            if (w_tickLast) begin
              r_tickCnt    <= '0;
              r_parityPend <= (^r_shift) ^ w_rxdS;
              r_state      <= STOP;
            end else begin
              r_tickCnt <= r_tickCnt + CW'(1);
            end
          end

          STOP: begin
            if (w_tickLast) begin
              r_tickCnt <= '0;
              r_state   <= w_rxdS ? IDLE : WAIT_HIGH;
              if (w_accept) begin
                r_data      <= r_shift;
                r_parityErr <= r_parityPend;
                r_frameErr  <= !w_rxdS;
                r_valid     <= 1'b1;
                r_overrun   <= 1'b0;
              end else begin
                r_overrun   <= 1'b1;
              end
            end else begin
              r_tickCnt <= r_tickCnt + CW'(1);
            end
          end

          WAIT_HIGH: begin
            if (w_rxdS) begin
              r_state <= IDLE;
            end
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_rx: serial frames are driven bit by bit, expected
// bytes go into a scoreboard queue and are popped by a handshake monitor.
module tb_uart_rx;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic baudTick = 1'b0;
  logic uartRxd  = 1'b1;
  logic uartRts;

  exp_t sbQ[$];
  int   total         = 0;
  int   bad           = 0;
  int   handshakes    = 0;
  int   validCycles   = 0;
  int   cycleCount    = 0;
  int   lastHsCycle   = 0;
  int   frameStart    = 0;
  int   hsSnap        = 0;
  int   vcSnap        = 0;
  int   latency       = 0;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(OVERSAMPLE)) dut (
    .clk      (clk),
    .reset    (reset),
    .baud_tick(baudTick),
    .uart_rxd (uartRxd),
    .uart_rts (uartRts),
    .rxBus    (bus)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  // Free-running cycle counter used to time deliveries
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Advance n clocks and settle just after the active edge
  task automatic stepClk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Single comparison point with failure accounting
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Queue an expected delivery
  task automatic expectFrame(input logic [7:0] d, input logic p, input logic f, input logic o);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.ferr = f;
    e.ovr  = o;
    sbQ.push_back(e);
  endtask

  // Drive one 11-bit frame on the serial line
  task automatic applyStimulus(input logic [7:0] d, input logic parityBit, input logic stopBit);
    uartRxd    = 1'b0;
    frameStart = cycleCount;
    stepClk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uartRxd = d[i];
      stepClk(BIT_CLKS);
    end
    uartRxd = parityBit;
    stepClk(BIT_CLKS);
    uartRxd = stopBit;
    stepClk(BIT_CLKS);
  endtask

  // Baud tick generator: one clk-wide pulse every TICK_DIV clocks
  initial begin
    forever begin
      stepClk(TICK_DIV - 1);
      baudTick = 1'b1;
      stepClk(1);
      baudTick = 1'b0;
    end
  end

  // Handshake monitor: every accepted byte must match the scoreboard head
  always @(negedge clk) begin
    if (bus.rx_valid) validCycles++;
    if (reset && bus.rx_valid && bus.rx_ready) begin
      exp_t e;
      handshakes++;
      lastHsCycle = cycleCount;
      checkOutput("sbHasEntry", 32'(sbQ.size() > 0), 1);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("hsData", bus.rx_data, e.data);
        checkOutput("hsParityErr", bus.parity_err, e.perr);
        checkOutput("hsFrameErr", bus.frame_err, e.ferr);
        checkOutput("hsOverrun", bus.overrun_err, e.ovr);
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    bus.rx_ready = 1'b1;
    reset        = 1'b0;
    uartRxd      = 1'b1;
    stepClk(4);

    $display("[TB] reset values");
    checkOutput("rstValid", bus.rx_valid, 0);
    checkOutput("rstData", bus.rx_data, 8'h00);
    checkOutput("rstParityErr", bus.parity_err, 0);
    checkOutput("rstFrameErr", bus.frame_err, 0);
    checkOutput("rstOverrun", bus.overrun_err, 0);
    checkOutput("rstRts", uartRts, 0);
    reset = 1'b1;
    stepClk(BIT_CLKS);

    $display("[TB] clean byte 0xA5");
    vcSnap = validCycles;
    expectFrame(8'hA5, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hA5, 1'b0, 1'b1);
    stepClk(BIT_CLKS);
    latency = lastHsCycle - frameStart;
    checkOutput("a5Drained", sbQ.size(), 0);
    checkOutput("a5Latency", 32'(latency >= 673 && latency <= 681), 1);
    checkOutput("a5ValidOneClk", validCycles - vcSnap, 1);
    checkOutput("a5RtsLow", uartRts, 0);

    $display("[TB] parity error 0x01");
    expectFrame(8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b1);
    stepClk(BIT_CLKS);
    checkOutput("parDrained", sbQ.size(), 0);

    $display("[TB] frame error 0x3C with line break");
    expectFrame(8'h3C, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h3C, 1'b0, 1'b0);
    hsSnap = handshakes;
    stepClk(40 * TICK_DIV);
    checkOutput("brkDrained", sbQ.size(), 0);
    checkOutput("brkNoSecond", handshakes, hsSnap);
    uartRxd = 1'b1;
    stepClk(12 * BIT_CLKS);
    checkOutput("brkNoFrameAfterRelease", handshakes, hsSnap);

    $display("[TB] start glitch");
    hsSnap = handshakes;
    vcSnap = validCycles;
    uartRxd = 1'b0;
    stepClk((OVERSAMPLE / 4) * TICK_DIV);
    uartRxd = 1'b1;
    stepClk(12 * BIT_CLKS);
    checkOutput("glitchNoValid", validCycles, vcSnap);
    checkOutput("glitchNoHs", handshakes, hsSnap);

    $display("[TB] overrun 0x11 then 0x22");
    bus.rx_ready = 1'b0;
    expectFrame(8'h11, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h11, 1'b0, 1'b1);
    applyStimulus(8'h22, 1'b0, 1'b1);
    stepClk(BIT_CLKS);
    checkOutput("ovrValid", bus.rx_valid, 1);
    checkOutput("ovrData", bus.rx_data, 8'h11);
    checkOutput("ovrFlag", bus.overrun_err, 1);
    checkOutput("ovrRts", uartRts, 1);
    checkOutput("ovrParityErr", bus.parity_err, 0);
    hsSnap = handshakes;
    bus.rx_ready = 1'b1;
    stepClk(1);
    bus.rx_ready = 1'b0;
    stepClk(2);
    checkOutput("ackOneHs", handshakes, hsSnap + 1);
    checkOutput("ackValid", bus.rx_valid, 0);
    checkOutput("ackOverrun", bus.overrun_err, 0);
    checkOutput("ackRts", uartRts, 0);
    checkOutput("ackDataHeld", bus.rx_data, 8'h11);
    checkOutput("ackDrained", sbQ.size(), 0);

    $display("[TB] reset during data bit 4");
    bus.rx_ready = 1'b1;
    hsSnap = handshakes;
    vcSnap = validCycles;
    fork
      applyStimulus(8'hF1, 1'b1, 1'b1);
      begin
        stepClk(5 * BIT_CLKS + 16);
        reset = 1'b0;
        stepClk(2);
        checkOutput("midRstData", bus.rx_data, 8'h00);
        checkOutput("midRstValid", bus.rx_valid, 0);
        checkOutput("midRstRts", uartRts, 0);
        checkOutput("midRstOverrun", bus.overrun_err, 0);
        reset = 1'b1;
      end
    join
    stepClk(4 * BIT_CLKS);
    checkOutput("midRstNoDelivery", validCycles, vcSnap);

    $display("[TB] clean byte 0x5A after reset");
    expectFrame(8'h5A, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h5A, 1'b0, 1'b1);
    stepClk(BIT_CLKS);
    checkOutput("postRstHs", handshakes, hsSnap + 1);
    checkOutput("postRstDrained", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter OVERSAMPLE, default 16: baud_tick pulses per bit period; legal values are even integers 8..32.
REQ-002 SHALL provide port clk, input, 1: single system clock (50 MHz); all logic rises on clk.
REQ-003 SHALL provide port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL provide port baud_tick, input, 1: one-clk-wide enable pulse at OVERSAMPLE x baud rate, from the rx baud generator.
REQ-005 SHALL provide port uart_rxd, input, 1: asynchronous serial line, idle high.
REQ-006 SHALL provide port rx_data, output, 8: received byte, held while rx_valid=1.
REQ-007 SHALL provide port rx_valid, output, 1: byte available.
REQ-008 SHALL provide port rx_ready, input, 1: consumer accepts byte when rx_valid=1 and rx_ready=1 in the same cycle.
REQ-009 SHALL provide ports parity_err, frame_err and overrun_err, output, 1 each: status qualified by rx_valid.
REQ-010 SHALL provide port uart_rts, output, 1: active-low request-to-send, equal to rx_valid (registered).

Function
REQ-011 SHALL pass uart_rxd through a 2-flop synchronizer; all sampling SHALL use the synchronized value rxd_s.
REQ-012 SHALL use frame format 1 start bit, 8 data bits LSB first, 1 even-parity bit, 1 stop bit (11 bits, 11*OVERSAMPLE ticks).
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; a tick counter and bit counter SHALL advance only on baud_tick.
REQ-014 IDLE: on a baud_tick with rxd_s=0, SHALL go to START with tick counter cleared.
REQ-015 START: at tick count OVERSAMPLE/2-1 (mid-bit), SHALL go to DATA with counters cleared if rxd_s=0, else return to IDLE (glitch rejected; no output change).
REQ-016 DATA: SHALL sample rxd_s each time the tick counter reaches OVERSAMPLE-1 (counter wraps to 0), shift it into the data register LSB first, and go to PARITY after the 8th sample.
REQ-017 PARITY: SHALL sample at count OVERSAMPLE-1; the parity error is (XOR of 8 data bits) XOR parity bit.
REQ-018 STOP: SHALL sample at count OVERSAMPLE-1 (the "delivery tick"); rxd_s=0 SHALL mark frame error and go to WAIT_HIGH, otherwise go to IDLE.
REQ-019 WAIT_HIGH: SHALL remain until a baud_tick with rxd_s=1, then go to IDLE (line-break protection).
REQ-020 On the delivery tick, if rx_valid=0 or rx_ready=1, outputs SHALL load on that clock edge: rx_data, parity_err, frame_err, rx_valid=1, overrun_err=0.
REQ-021 Frames with parity or frame error SHALL still be delivered with their flag set.
REQ-022 On the delivery tick, if rx_valid=1 and rx_ready=0, the new byte SHALL be discarded, rx_data and its flags SHALL be kept, and overrun_err SHALL be set to 1.
REQ-023 A handshake (rx_valid and rx_ready) without a simultaneous delivery SHALL clear rx_valid, parity_err, frame_err and overrun_err on the next edge; rx_data SHALL hold its value.
REQ-024 rx_ready SHALL have no effect while rx_valid=0.
REQ-025 baud_tick asserted for consecutive clks SHALL be counted as one tick per clk.

Reset
REQ-026 With reset=0 at a clk edge, the FSM SHALL enter IDLE, counters SHALL be 0, synchronizer flops SHALL be 1, and rx_data=0x00, rx_valid=0, all error flags=0, uart_rts=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no delivery; after release, reception SHALL begin at the next falling start bit.

Verification
REQ-028 Bench SHALL send 0xA5 with parity 0 and stop 1, rx_ready=1 -> rx_data=0xA5, rx_valid high for 1 clk, all flags 0, delivery within 3 clks of the tick at bit 10 mid-point.
REQ-029 Bench SHALL send 0x01 with parity 0 (wrong) -> rx_data=0x01, parity_err=1, frame_err=0.
REQ-030 Bench SHALL send 0x3C with stop=0, then hold the line low for 40 ticks, then release -> frame_err=1; no second frame is decoded until the line is high again.
REQ-031 Bench SHALL apply a low glitch of OVERSAMPLE/4 ticks in IDLE -> no rx_valid, and the FSM returns to IDLE.
REQ-032 Bench SHALL send 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data stays 0x11, overrun_err=1, uart_rts=1; pulsing rx_ready for 1 clk -> rx_valid=0, overrun_err=0.
REQ-033 Bench SHALL assert reset=0 during DATA bit 4 of a frame -> all outputs return to reset values, no delivery; the next clean frame 0x5A is received correctly.
